// File: rtl/thermo_sequencer.sv
// thermo_sequencer: slew-limited binary-to-thermometer driver.
// Accepts a target code over valid/ready, clamps it to ThermoWidth, and ramps the applied level
// toward it in steps of at most MaxStep, holding SettleCycles after each step.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   code_valid_i, code_i target code offer (unsigned, BinWidth bits)
//   code_ready_o         high in idle; a code transfers on valid && ready
//   thermo_o             registered thermometer, bit i set iff i < level
//   level_o              registered applied level
//   busy_o               ramp in progress
//   done_o               one-cycle pulse when the target is reached
//   code_clamped_o       one-cycle pulse when an accepted code exceeded ThermoWidth
module thermo_sequencer #(
  parameter int unsigned ThermoWidth  = 256,
  parameter int unsigned BinWidth     = $clog2(ThermoWidth + 1),
  parameter int unsigned MaxStep      = 16,
  parameter int unsigned SettleCycles = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   code_valid_i,
  input  logic [BinWidth-1:0]    code_i,
  output logic                   code_ready_o,
  output logic [ThermoWidth-1:0] thermo_o,
  output logic [BinWidth-1:0]    level_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   code_clamped_o
);

  localparam logic [BinWidth-1:0] FullLevel  = BinWidth'(ThermoWidth);
  localparam logic [BinWidth-1:0] StepMax    = BinWidth'(MaxStep);
  localparam logic                HasSettle  = (SettleCycles > 0);
  localparam logic [7:0]          SettleLoad = HasSettle ? 8'(SettleCycles - 1) : 8'd0;

  typedef enum logic [1:0] {StIdle, StStep, StSettle} state_e;

  state_e                 state_q, state_d;
  logic [BinWidth-1:0]    level_q, level_d;
  logic [BinWidth-1:0]    target_q, target_d;
  logic [7:0]             settle_q, settle_d;
  logic [ThermoWidth-1:0] thermo_q, thermo_d;
  logic                   done_q, done_d;
  logic                   clamped_q;
  // Accept-time events are reported one cycle after the accepting edge.
  logic                   eq_pend_q, eq_pend_d;
  logic                   clamp_pend_q, clamp_pend_d;

  logic                   up;
  logic [BinWidth-1:0]    diff;
  logic [BinWidth-1:0]    step;
  logic [BinWidth-1:0]    code_sel;

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    target_d     = target_q;
    settle_d     = settle_q;
    eq_pend_d    = 1'b0;
    clamp_pend_d = 1'b0;
    done_d       = eq_pend_q;

    // Compare first, then subtract smaller from larger: no wrap possible.
    up       = (target_q > level_q);
    diff     = up ? (target_q - level_q) : (level_q - target_q);
    step     = (diff > StepMax) ? StepMax : diff;
    code_sel = (code_i > FullLevel) ? FullLevel : code_i;

    unique case (state_q)
      StIdle: begin
        if (code_valid_i) begin
          target_d     = code_sel;
          clamp_pend_d = (code_i > FullLevel);
          if (code_sel == level_q) begin
            eq_pend_d = 1'b1;
          end else begin
            state_d = StStep;
          end
        end
      end
      StStep: begin
        level_d = up ? (level_q + step) : (level_q - step);
        if (HasSettle) begin
          state_d  = StSettle;
          settle_d = SettleLoad;
        end else if (level_d == target_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      StSettle: begin
        if (settle_q == 8'd0) begin
          if (level_q == target_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StStep;
          end
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Decode from next-state level so thermo and level update on the same edge.
  always_comb begin
    thermo_d = '0;
    for (int unsigned i = 0; i < ThermoWidth; i++) begin
      thermo_d[i] = (32'(level_d) > i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      level_q      <= '0;
      target_q     <= '0;
      settle_q     <= 8'd0;
      thermo_q     <= '0;
      done_q       <= 1'b0;
      clamped_q    <= 1'b0;
      eq_pend_q    <= 1'b0;
      clamp_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      target_q     <= target_d;
      settle_q     <= settle_d;
      thermo_q     <= thermo_d;
      done_q       <= done_d;
      clamped_q    <= clamp_pend_q;
      eq_pend_q    <= eq_pend_d;
      clamp_pend_q <= clamp_pend_d;
    end
  end

  assign code_ready_o   = (state_q == StIdle);
  assign busy_o         = (state_q != StIdle);
  assign thermo_o       = thermo_q;
  assign level_o        = level_q;
  assign done_o         = done_q;
  assign code_clamped_o = clamped_q;

endmodule

// File: tb/tb_thermo_sequencer.sv
// Directed testbench for thermo_sequencer at default parameters (256/16/2).
module tb_thermo_sequencer;

  logic         clk;
  logic         rst_n;
  logic         code_valid;
  logic [8:0]   code;
  logic         code_ready;
  logic [255:0] thermo;
  logic [8:0]   level;
  logic         busy;
  logic         done;
  logic         code_clamped;

  int n_checks = 0;
  int n_fail   = 0;

  int up40   [9]  = '{16, 16, 16, 32, 32, 32, 40, 40, 40};
  int dn5    [9]  = '{24, 24, 24, 8, 8, 8, 5, 5, 5};
  int dn200  [4]  = '{240, 240, 240, 224};
  int up100  [21] = '{16, 16, 16, 32, 32, 32, 48, 48, 48, 64, 64, 64,
                      80, 80, 80, 96, 96, 96, 100, 100, 100};

  thermo_sequencer dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .code_valid_i   (code_valid),
    .code_i         (code),
    .code_ready_o   (code_ready),
    .thermo_o       (thermo),
    .level_o        (level),
    .busy_o         (busy),
    .done_o         (done),
    .code_clamped_o (code_clamped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] exp_thermo(input int lvl);
    logic [255:0] r;
    for (int i = 0; i < 256; i++) r[i] = (i < lvl);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_code(input int c);
    code       = 9'(c);
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; code_valid = 1'b0; code = '0;
    #2;
    n_checks++;
    if (thermo !== '0 || level !== 9'd0) begin
      n_fail++; $display("FAIL reset_held: level=%0d thermo=%h required 0", level, thermo);
    end
    #20;
    @(negedge clk) rst_n = 1'b1;
    tick(); tick();
    n_checks++;
    if (thermo !== '0 || level !== 9'd0) begin
      n_fail++; $display("FAIL reset_idle_level: level=%0d thermo=%h required 0", level, thermo);
    end
    n_checks++;
    if (code_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_ready: ready=%b busy=%b required 1/0", code_ready, busy);
    end
    n_checks++;
    if (done !== 1'b0 || code_clamped !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_pulses: done=%b clamped=%b required 0/0", done,
                         code_clamped);
    end
  endtask

  task automatic test_ramp_up();
    send_code(40);
    n_checks++;
    if (busy !== 1'b1 || code_ready !== 1'b0 || level !== 9'd0) begin
      n_fail++; $display("FAIL up40_accept: busy=%b ready=%b level=%0d required 1/0/0", busy,
                         code_ready, level);
    end
    for (int j = 1; j <= 9; j++) begin
      tick();
      n_checks++;
      if (level !== 9'(up40[j-1]) || thermo !== exp_thermo(up40[j-1])) begin
        n_fail++; $display("FAIL up40_level edge k+%0d: level=%0d required %0d thermo=%h", j,
                           level, up40[j-1], thermo);
      end
      n_checks++;
      if (done !== (j == 9) || busy !== (j < 9) || code_clamped !== 1'b0) begin
        n_fail++; $display("FAIL up40_flags edge k+%0d: done=%b busy=%b clamped=%b", j, done,
                           busy, code_clamped);
      end
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL up40_done_width: done=%b required 0", done);
    end
  endtask

  task automatic test_ramp_down();
    send_code(5);
    for (int j = 1; j <= 9; j++) begin
      tick();
      n_checks++;
      if (level !== 9'(dn5[j-1]) || thermo !== exp_thermo(dn5[j-1])) begin
        n_fail++; $display("FAIL dn5_level edge k+%0d: level=%0d required %0d thermo=%h", j,
                           level, dn5[j-1], thermo);
      end
      n_checks++;
      if (done !== (j == 9) || busy !== (j < 9)) begin
        n_fail++; $display("FAIL dn5_flags edge k+%0d: done=%b busy=%b", j, done, busy);
      end
    end
    tick();
  endtask

  task automatic test_ramp_to_zero();
    send_code(0);
    for (int j = 1; j <= 3; j++) begin
      tick();
      n_checks++;
      if (level !== 9'd0 || thermo !== '0 || done !== (j == 3) || busy !== (j < 3)) begin
        n_fail++; $display("FAIL zero edge k+%0d: level=%0d done=%b busy=%b thermo=%h", j,
                           level, done, busy, thermo);
      end
    end
    tick();
  endtask

  task automatic test_clamp();
    int exp_lvl;
    send_code(300);
    for (int j = 1; j <= 48; j++) begin
      tick();
      exp_lvl = 16 * ((j - 1) / 3 + 1);
      n_checks++;
      if (level !== 9'(exp_lvl) || thermo !== exp_thermo(exp_lvl)) begin
        n_fail++; $display("FAIL clamp_level edge k+%0d: level=%0d required %0d", j, level,
                           exp_lvl);
      end
      n_checks++;
      if (code_clamped !== (j == 1) || done !== (j == 48) || busy !== (j < 48)) begin
        n_fail++; $display("FAIL clamp_flags edge k+%0d: clamped=%b done=%b busy=%b", j,
                           code_clamped, done, busy);
      end
    end
    n_checks++;
    if (thermo !== {256{1'b1}} || level !== 9'd256) begin
      n_fail++; $display("FAIL clamp_full: level=%0d thermo=%h required 256 all ones", level,
                         thermo);
    end
  endtask

  task automatic test_back_to_back();
    tick();
    code = 9'd256; code_valid = 1'b1;
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || code_ready !== 1'b1) begin
      n_fail++; $display("FAIL eq_accept: done=%b busy=%b ready=%b required 0/0/1", done, busy,
                         code_ready);
    end
    code = 9'd300;
    tick();
    code_valid = 1'b0;
    n_checks++;
    if (done !== 1'b1 || code_clamped !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL eq_done: done=%b clamped=%b busy=%b required 1/0/0", done,
                         code_clamped, busy);
    end
    n_checks++;
    if (thermo !== {256{1'b1}} || level !== 9'd256) begin
      n_fail++; $display("FAIL eq_unchanged: level=%0d required 256", level);
    end
    tick();
    n_checks++;
    if (done !== 1'b1 || code_clamped !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_done: done=%b clamped=%b busy=%b required 1/1/0", done,
                         code_clamped, busy);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || code_clamped !== 1'b0 || level !== 9'd256) begin
      n_fail++; $display("FAIL b2b_quiet: done=%b clamped=%b level=%0d required 0/0/256", done,
                         code_clamped, level);
    end
  endtask

  task automatic test_reset_mid_ramp();
    code = 9'd200; code_valid = 1'b1;
    tick();
    code = 9'd100;
    for (int j = 1; j <= 4; j++) begin
      tick();
      n_checks++;
      if (level !== 9'(dn200[j-1]) || busy !== 1'b1 || code_ready !== 1'b0) begin
        n_fail++; $display("FAIL hold_busy edge k+%0d: level=%0d required %0d busy=%b ready=%b",
                           j, level, dn200[j-1], busy, code_ready);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (level !== 9'd0 || thermo !== '0) begin
      n_fail++; $display("FAIL async_reset_level: level=%0d thermo=%h required 0", level, thermo);
    end
    n_checks++;
    if (busy !== 1'b0 || code_ready !== 1'b1 || done !== 1'b0 || code_clamped !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_flags: busy=%b ready=%b done=%b clamped=%b", busy,
                         code_ready, done, code_clamped);
    end
    #2;
    rst_n = 1'b1;
    tick();
    code_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || level !== 9'd0) begin
      n_fail++; $display("FAIL post_reset_accept: busy=%b level=%0d required 1/0", busy, level);
    end
    for (int j = 1; j <= 21; j++) begin
      tick();
      n_checks++;
      if (level !== 9'(up100[j-1]) || thermo !== exp_thermo(up100[j-1])) begin
        n_fail++; $display("FAIL up100_level edge k+%0d: level=%0d required %0d", j, level,
                           up100[j-1]);
      end
      n_checks++;
      if (done !== (j == 21) || busy !== (j < 21)) begin
        n_fail++; $display("FAIL up100_flags edge k+%0d: done=%b busy=%b", j, done, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_ramp_to_zero();
    test_clamp();
    test_back_to_back();
    test_reset_mid_ramp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
